// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation and state encodings for the multiply/divide unit.
package mdu_pkg;
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} mdu_state_t;
endpackage

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide unit with valid/ready handshakes and flush.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] left_operand,
    input  logic [WIDTH-1:0] right_operand,
    input  logic             flush,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);
    localparam int CW = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg_x);
        return neg_x ? negate(x) : x;
    endfunction

    mdu_state_t         state;
    mdu_op_t            op_q;
    logic               sign_l, sign_r;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               l_neg, r_neg, div_zero, div_ovf, is_div, ge;
    logic [WIDTH-1:0]   special_res, quo, rem, fix_res;
    logic [WIDTH:0]     add_a, add_b, sum;
    logic [2*WIDTH-1:0] step, prod;

    always_comb begin
        l_neg       = (op inside {MULH, MULHSU, DIV, REM}) && left_operand[WIDTH-1];
        r_neg       = (op inside {MULH, DIV, REM}) && right_operand[WIDTH-1];
        div_zero    = (op inside {DIV, DIVU, REM, REMU}) && right_operand == '0;
        div_ovf     = (op inside {DIV, REM}) && left_operand == {1'b1, {(WIDTH-1){1'b0}}} && &right_operand;
        special_res = div_zero ? ((op inside {REM, REMU}) ? left_operand : '1)
                               : ((op == REM) ? '0 : left_operand);
        is_div      = op_q inside {DIV, DIVU, REM, REMU};
        // one shared W+1-bit adder: shift-add for multiply, trial subtract for divide
        add_a       = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_b       = {1'b0, divisor};
        sum         = is_div ? add_a - add_b : add_a + (acc[0] ? add_b : '0);
        ge          = ~sum[WIDTH];
        step        = is_div ? {ge ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], ge}
                             : {sum, acc[WIDTH-1:1]};
        prod        = (sign_l ^ sign_r) ? -acc : acc;
        quo         = (sign_l ^ sign_r) ? negate(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem         = sign_l ? negate(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        fix_res     = is_div ? ((op_q inside {REM, REMU}) ? rem : quo)
                             : ((op_q == MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= MUL;
            sign_l    <= 1'b0;
            sign_r    <= 1'b0;
            divisor   <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    op_q      <= op;
                    sign_l    <= l_neg;
                    sign_r    <= r_neg;
                    divisor   <= mag(right_operand, r_neg);
                    acc       <= {{WIDTH{1'b0}}, mag(left_operand, l_neg)};
                    cnt       <= '0;
                    ready_out <= 1'b0;
                    if (div_zero || div_ovf) begin
                        result    <= special_res;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
                end
                FIXUP: begin
                    result    <= fix_res;
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (ready_in) begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign zero_flag = result == '0;
endmodule
